// File: rtl/gf_serial_reducer.sv
// Bit-serial GF(2^m) reducer: one product bit per cycle, responder on op_enable/op_finish.
// Optional build macro GF_RED_EARLY_EXIT_EN ends the reduction once no bits remain at or above m.
module gf_serial_reducer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            op_enable,
  output logic                            op_finish,
  output logic                            op_error,
  output logic                            op_busy,
  input  logic [$clog2(DATA_WIDTH):0]     polyn_grade,
  input  logic [DATA_WIDTH:0]             polyn_red_in,
  input  logic [2*DATA_WIDTH-1:0]         reduc_in,
  output logic [DATA_WIDTH-1:0]           out_poly
);

  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int RW = 2 * DATA_WIDTH;
  localparam int IW = $clog2(RW);
`ifdef GF_RED_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         m_q, m_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] out_poly_q, out_poly_d;
  logic                  op_error_q, op_error_d;
  logic                  op_finish_q, op_finish_d;
  logic                  op_busy_q, op_busy_d;

  logic                  m_ok_s;
  logic [RW-1:0]         in_mask_s;
  logic [DATA_WIDTH:0]   tail_mask_s;
  logic [DATA_WIDTH-1:0] res_mask_s;
  logic [RW-1:0]         tail_sh_s;
  logic [RW-1:0]         rem_upd_s;
  logic                  hi_zero_s;

  // Datapath helpers: input masks, one reduction step and the early-exit test.
  always_comb begin
    m_ok_s      = (polyn_grade >= GW'(2)) && (polyn_grade <= GW'(DATA_WIDTH));
    in_mask_s   = ~({RW{1'b1}} << ((32'(polyn_grade) << 1) - 32'd1));
    tail_mask_s = ~({(DATA_WIDTH+1){1'b1}} << polyn_grade);
    res_mask_s  = ~({DATA_WIDTH{1'b1}} << m_q);
    tail_sh_s   = {{(RW-DATA_WIDTH){1'b0}}, tail_q} << (idx_q - IW'(m_q));
    if (rem_q[idx_q]) begin
      rem_upd_s = rem_q ^ tail_sh_s ^ ({{(RW-1){1'b0}}, 1'b1} << idx_q);
    end else begin
      rem_upd_s = rem_q;
    end
    // Bits above idx are already zero, so this is rem[idx:m]==0.
    hi_zero_s = ((rem_q >> m_q) == {RW{1'b0}});
  end

  // Next-state and registered-output computation for the handshake FSM.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    tail_d      = tail_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    out_poly_d  = out_poly_q;
    op_error_d  = op_error_q;
    op_finish_d = op_finish_q;
    case (state_q)
      S_IDLE: begin
        op_finish_d = 1'b0;
        if (op_enable && m_ok_s) begin
          m_d     = polyn_grade;
          tail_d  = DATA_WIDTH'(polyn_red_in & tail_mask_s);
          rem_d   = reduc_in & in_mask_s;
          idx_d   = IW'((32'(polyn_grade) << 1) - 32'd2);
          state_d = S_REDUCE;
        end else if (op_enable) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDUCE: begin
        if (!op_enable) begin
          state_d = S_IDLE;
        end else if (EARLY_EXIT && hi_zero_s) begin
          out_poly_d  = rem_q[DATA_WIDTH-1:0] & res_mask_s;
          op_error_d  = 1'b0;
          op_finish_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          rem_d = rem_upd_s;
          idx_d = idx_q - IW'(1);
          if (idx_q == IW'(m_q)) begin
            out_poly_d  = rem_upd_s[DATA_WIDTH-1:0] & res_mask_s;
            op_error_d  = 1'b0;
            op_finish_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_REDUCE;
          end
        end
      end
      S_DONE: begin
        if (!op_enable) begin
          op_finish_d = 1'b0;
          state_d     = S_IDLE;
        end else if (!op_finish_q) begin
          // Only the out-of-range path arrives here without op_finish set.
          op_finish_d = 1'b1;
          op_error_d  = 1'b1;
          out_poly_d  = {DATA_WIDTH{1'b0}};
        end else begin
          op_finish_d = 1'b1;
        end
      end
      default: begin
        op_finish_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    op_busy_d = (state_d == S_REDUCE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      m_q         <= {GW{1'b0}};
      tail_q      <= {DATA_WIDTH{1'b0}};
      rem_q       <= {RW{1'b0}};
      idx_q       <= {IW{1'b0}};
      out_poly_q  <= {DATA_WIDTH{1'b0}};
      op_error_q  <= 1'b0;
      op_finish_q <= 1'b0;
      op_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      tail_q      <= tail_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      out_poly_q  <= out_poly_d;
      op_error_q  <= op_error_d;
      op_finish_q <= op_finish_d;
      op_busy_q   <= op_busy_d;
    end
  end

  assign op_finish = op_finish_q;
  assign op_error  = op_error_q;
  assign op_busy   = op_busy_q;
  assign out_poly  = out_poly_q;

endmodule
